// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: sequential READ/WRITE with a 16-bit address into an internal byte array.
// Optional build macro IDLI_SQI_MEM_RDMR_EN adds the mode-register read opcode 8'h05.
module idli_sqi_mem_m #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst_n,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
`ifdef IDLI_SQI_MEM_RDMR_EN
    localparam logic [7:0] CMD_RDMR = 8'h05;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;

    state_t            state;
    logic              sck_q;
    logic [1:0]        cnt;
    logic              nib_idx;
    logic [3:0]        cmd_hi;
    logic [3:0]        wr_hi;
    logic              is_read;
    logic              mode_rd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        mem [DEPTH];

    logic       rise;
    logic       fall;
    logic       wr_en;
    logic [7:0] opcode;
    logic [7:0] rd_byte;

    // sck is a sampled qualifier; edges are ignored while deselected.
    assign rise    = i_mem_sck & ~sck_q & ~i_mem_cs;
    assign fall    = ~i_mem_sck & sck_q & ~i_mem_cs;
    assign opcode  = {cmd_hi, i_mem_sio};
    assign rd_byte = mode_rd ? 8'h40 : mem[addr];
    assign wr_en   = (state == WDATA) && rise && nib_idx;

    // NOTE: the storage array has no reset branch; resetting it would forbid RAM inference.
    always_ff @(posedge i_mem_gck) begin
        if (wr_en) begin
            mem[addr] <= {wr_hi, i_mem_sio};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            state        <= IDLE;
            sck_q        <= 1'b0;
            cnt          <= '0;
            nib_idx      <= 1'b0;
            cmd_hi       <= '0;
            wr_hi        <= '0;
            is_read      <= 1'b0;
            mode_rd      <= 1'b0;
            addr         <= '0;
            o_mem_sio    <= '0;
            o_mem_sio_oe <= 1'b0;
        end else begin
            sck_q <= i_mem_sck;
            if (i_mem_cs) begin
                // Deselect wins over any edge in the same cycle, dropping a half-finished byte.
                state        <= IDLE;
                cnt          <= '0;
                nib_idx      <= 1'b0;
                mode_rd      <= 1'b0;
                o_mem_sio    <= '0;
                o_mem_sio_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CMD;
                        cnt     <= '0;
                        nib_idx <= 1'b0;
                    end
                    CMD: if (rise) begin
                        cmd_hi <= i_mem_sio;
                        cnt    <= cnt + 2'd1;
                        if (cnt[0]) begin
                            cnt <= '0;
                            if (opcode == CMD_READ) begin
                                is_read <= 1'b1;
                                state   <= ADDR;
                            end else if (opcode == CMD_WRITE) begin
                                is_read <= 1'b0;
                                state   <= ADDR;
`ifdef IDLI_SQI_MEM_RDMR_EN
                            end else if (opcode == CMD_RDMR) begin
                                mode_rd <= 1'b1;
                                state   <= DUMMY;
`endif
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR: if (rise) begin
                        // Shifting through a narrow register keeps only the low ADDR_W address bits.
                        addr <= ADDR_W'({addr, i_mem_sio});
                        cnt  <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            nib_idx <= 1'b0;
                            state   <= is_read ? DUMMY : WDATA;
                        end
                    end
                    DUMMY: if (rise) begin
                        cnt <= cnt + 2'd1;
                        if (cnt[0]) begin
                            cnt     <= '0;
                            nib_idx <= 1'b0;
                            state   <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (fall) begin
                            o_mem_sio    <= nib_idx ? rd_byte[3:0] : rd_byte[7:4];
                            o_mem_sio_oe <= 1'b1;
                        end
                        if (rise) begin
                            nib_idx <= ~nib_idx;
                            if (nib_idx && !mode_rd) begin
                                addr <= addr + ADDR_W'(1);
                            end
                        end
                    end
                    WDATA: if (rise) begin
                        if (!nib_idx) begin
                            wr_hi   <= i_mem_sio;
                            nib_idx <= 1'b1;
                        end else begin
                            nib_idx <= 1'b0;
                            addr    <= addr + ADDR_W'(1);
                        end
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for idli_sqi_mem_m: write/read, wrap, abort, unknown opcode, async reset, mode read.
module tb_idli_sqi_mem_m;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck;
    logic       cs;
    logic [3:0] sio;
    logic [3:0] sio_out;
    logic       sio_oe;

    int total = 0;
    int bad   = 0;

    idli_sqi_mem_m dut (
        .i_mem_gck   (clk),
        .i_mem_rst_n (rst_n),
        .i_mem_sck   (sck),
        .i_mem_cs    (cs),
        .i_mem_sio   (sio),
        .o_mem_sio   (sio_out),
        .o_mem_sio_oe(sio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One sck pulse (2 gck high, 2 gck low); q is the responder output seen as sck rises.
    task automatic nib(input logic [3:0] d, output logic [3:0] q);
        q   = sio_out;
        sck = 1'b1;
        sio = d;
        repeat (2) @(negedge clk);
        sck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] q;
        nib(b[7:4], q);
        nib(b[3:0], q);
    endtask

    task automatic begin_cmd(input logic [7:0] op, input logic [15:0] a);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(op);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic end_cs(input string tag);
        cs = 1'b1;
        @(negedge clk);
        check({tag, "_oe_off"}, 32'(sio_oe), 32'd0);
        check({tag, "_sio_off"}, 32'(sio_out), 32'd0);
    endtask

    task automatic wr2(input logic [15:0] a, input logic [15:0] d);
        begin_cmd(8'h02, a);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        end_cs("wr");
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input int n, input logic [15:0] exp);
        logic [3:0]  q;
        logic [15:0] got;
        got = '0;
        begin_cmd(8'h03, a);
        check({tag, "_oe_addr"}, 32'(sio_oe), 32'd0);
        send_byte(8'h00);
        for (int i = 0; i < n; i++) begin
            if (i == 0) check({tag, "_oe_data"}, 32'(sio_oe), 32'd1);
            nib(4'h0, q);
            got = {got[11:0], q};
        end
        check({tag, "_data"}, 32'(got), 32'(exp));
        end_cs(tag);
    endtask

    initial begin
        logic [3:0]  q;
        logic [15:0] got;
        rst_n = 1'b0;
        cs    = 1'b1;
        sck   = 1'b0;
        sio   = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_oe", 32'(sio_oe), 32'd0);
        check("rst_sio", 32'(sio_out), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write then read-back at 0x0010.
        wr2(16'h0010, 16'hA53C);
        rd_check("basic", 16'h0010, 4, 16'hA53C);

        // Address wrap and ignored upper address bits.
        wr2(16'h00FF, 16'h1122);
        rd_check("wrap0", 16'h0000, 2, 16'h0022);
        rd_check("upper", 16'h01FF, 2, 16'h0011);
        rd_check("rdwrap", 16'h00FF, 4, 16'h1122);

        // Partial byte discarded on deselect.
        begin_cmd(8'h02, 16'h0020);
        send_byte(8'h77);
        nib(4'h9, q);
        end_cs("partial");
        rd_check("partial", 16'h0020, 2, 16'h0077);

        // Deselect in the same cycle as the completing rise: byte must not land.
        begin_cmd(8'h02, 16'h0020);
        nib(4'h1, q);
        sck = 1'b1;
        sio = 4'h2;
        cs  = 1'b1;
        @(negedge clk);
        check("same_cyc_oe", 32'(sio_oe), 32'd0);
        sck = 1'b0;
        repeat (2) @(negedge clk);
        rd_check("same_cyc", 16'h0020, 2, 16'h0077);

        // Unknown opcode: responder stays off the bus.
        begin_cmd(8'hFF, 16'h0000);
        for (int i = 0; i < 14; i++) begin
            nib(4'h0, q);
            check("unk_oe", 32'(sio_oe), 32'd0);
        end
        end_cs("unk");
        rd_check("after_unk", 16'h0010, 4, 16'hA53C);

        // Async reset in the middle of read data.
        begin_cmd(8'h03, 16'h0010);
        send_byte(8'h00);
        nib(4'h0, q);
        check("arst_first", 32'(q), 32'hA);
        check("arst_oe_pre", 32'(sio_oe), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_oe", 32'(sio_oe), 32'd0);
        check("arst_sio", 32'(sio_out), 32'd0);
        cs = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_check("after_rst", 16'h0011, 2, 16'h003C);

        // Mode-register read.
        cs = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h05);
        send_byte(8'h00);
        got = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef IDLI_SQI_MEM_RDMR_EN
            check("rdmr_oe", 32'(sio_oe), 32'd1);
`else
            check("rdmr_oe", 32'(sio_oe), 32'd0);
`endif
            nib(4'h0, q);
            got = {got[11:0], q};
        end
`ifdef IDLI_SQI_MEM_RDMR_EN
        check("rdmr_data", 32'(got), 32'h4040);
`endif
        end_cs("rdmr");
        rd_check("after_rdmr", 16'h0010, 2, 16'h00A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
